ballot_session_ctrl: RTL and testbench
======================================

// Module: ballot_session_ctrl
// PURPOSE
//   Sequences and polices ballots for the 4-candidate voting machine. Sits between the per-button
//   debounce pulses and the vote logger: a poll officer arms one ballot, exactly one candidate
//   press is accepted, then the ballot is consumed. Rejects simultaneous, unarmed and timed-out presses.
// PARAMETERS
//   NUM_CAND     4     number of candidates / width of cand_valid and vote_en
//   CNT_W        8     width of total_votes (and reject_count)
//   TIMEOUT_CYC  1000  ARMED cycles allowed before the ballot is voided (>=2)
//   LOCKOUT_CYC  10    cycles after a commit during which all presses are ignored (>=1)
// PORTS
//   clk           in   1         system clock, rising edge
//   rst           in   1         asynchronous, active-high reset
//   session_open  in   1         level; polls open while high
//   arm           in   1         officer pulse; issues one ballot
//   cand_valid    in   NUM_CAND  single-cycle valid-vote pulses from button debouncers
//   vote_en       out  NUM_CAND  one-hot, one-cycle increment strobe to vote logger
//   vote_ack      out  1         one-cycle pulse, coincident with vote_en
//   reject        out  1         one-cycle pulse, press refused
//   timeout       out  1         one-cycle pulse, ballot voided by timer
//   ballot_armed  out  1         high while in ARMED
//   state         out  3         current FSM state encoding (debug/LED mux)
//   total_votes   out  CNT_W     committed ballots this power-up, saturating
// BEHAVIOUR
//   All outputs registered. Reset: state=CLOSED; vote_en=0; all pulses=0; ballot_armed=0; counters=0.
//   States: CLOSED, IDLE, ARMED, COMMIT, LOCKOUT.
//   CLOSED : session_open=1 -> IDLE. Presses and arm ignored silently.
//   IDLE   : session_open=0 -> CLOSED; else arm -> ARMED (timer cleared); else any cand_valid -> reject.
//   ARMED  : priority, highest first:
//     1 session_open=0 -> CLOSED; ballot voided; no vote_en, no timeout pulse.
//     2 cand_valid exactly one bit set -> COMMIT; candidate index latched.
//     3 cand_valid >1 bit set -> reject; stay ARMED; ballot not consumed; timer keeps running.
//     4 timer reaches TIMEOUT_CYC-1 -> IDLE; timeout pulses in the first IDLE cycle.
//     arm while ARMED is ignored; timer does not restart.
//   COMMIT : exactly 1 cycle. vote_en=onehot(index); vote_ack=1; total_votes+1, saturating at 2^CNT_W-1
//            (vote_en still issued when saturated) -> LOCKOUT.
//   LOCKOUT: LOCKOUT_CYC cycles; cand_valid and arm ignored, no reject. Then -> IDLE, or CLOSED if
//            session_open=0 at exit. A close during LOCKOUT never cancels the committed vote.
//   Latency: accepted press in cycle N -> vote_en/vote_ack in cycle N+1.
//   vote_en is never multi-hot and is never asserted outside COMMIT.
//   rst asserted mid-operation returns to CLOSED immediately. Any in-flight ballot is lost.
//   Counters are cleared by rst.
// CONFIGURATION
//   REJECT_COUNT_EN defined: extra output reject_count [CNT_W-1:0], reset 0.
//     +1 on every reject pulse, saturating. Timeouts are not counted.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package ballot_ctrl_pkg holds:
//     state typedef/encodings CLOSED=0, IDLE=1, ARMED=2, COMMIT=3, LOCKOUT=4
//     NUM_CAND default
//   One sub-module: cand_onehot_enc (combinational). Inputs cand_valid.
//     Outputs: none, exactly_one, multi, and a binary index.
//   Timer and lockout share one down-counter sized $clog2(max(TIMEOUT_CYC, LOCKOUT_CYC)).
// TESTING
//   1 Open, arm, cand_valid=4'b0100 at N -> vote_en=4'b0100 and vote_ack only at N+1;
//     total_votes=1; IDLE after 10 LOCKOUT cycles.
//   2 ARMED, cand_valid=4'b0011 -> reject=1, vote_en=0, ballot_armed stays 1;
//     next 4'b0001 -> vote_en=4'b0001.
//   3 TIMEOUT_CYC=20, arm, no press -> timeout pulse after 20 ARMED cycles; state=IDLE;
//     later press -> reject, no vote_en.
//   4 Press during LOCKOUT -> no reject, no vote_en.
//     Press in IDLE -> reject; reject_count=1 with REJECT_COUNT_EN.
//   5 ARMED, drop session_open -> CLOSED next cycle; no vote_en; arm ignored until reopen.
//   6 rst asserted mid-ARMED, between clock edges -> all outputs 0 and state=CLOSED before next edge.
//     CNT_W=2 saturation: four commits -> total_votes=3, vote_en still pulses.

Source files
------------

// File: rtl/ballot_session_ctrl_pkg.sv
// Shared state encodings and defaults for the ballot session controller.
`default_nettype none

package ballot_ctrl_pkg;

  localparam int NUM_CAND_DEF = 4;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    IDLE    = 3'd1,
    ARMED   = 3'd2,
    COMMIT  = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ballot_session_ctrl_if.sv
// Bus bundle between officer/button front end (master) and the ballot controller (slave).
`default_nettype none

interface ballot_session_ctrl_if #(
  parameter int NUM_CAND = ballot_ctrl_pkg::NUM_CAND_DEF,
  parameter int CNT_W    = 8
);

  logic                session_open;
  logic                arm;
  logic [NUM_CAND-1:0] cand_valid;
  logic [NUM_CAND-1:0] vote_en;
  logic                vote_ack;
  logic                reject;
  logic                timeout;
  logic                ballot_armed;
  logic [2:0]          state;
  logic [CNT_W-1:0]    total_votes;
`ifdef REJECT_COUNT_EN
  logic [CNT_W-1:0]    reject_count;
`endif

  modport master (
    output session_open, arm, cand_valid,
`ifdef REJECT_COUNT_EN
    input  reject_count,
`endif
    input  vote_en, vote_ack, reject, timeout, ballot_armed, state, total_votes
  );

  modport slave (
    input  session_open, arm, cand_valid,
`ifdef REJECT_COUNT_EN
    output reject_count,
`endif
    output vote_en, vote_ack, reject, timeout, ballot_armed, state, total_votes
  );

endinterface

`default_nettype wire

// File: rtl/ballot_session_ctrl_enc.sv
// Classifies the candidate press vector: none, exactly one, multiple, plus binary index.
`default_nettype none

module cand_onehot_enc #(
  parameter int NUM_CAND = ballot_ctrl_pkg::NUM_CAND_DEF,
  parameter int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic [NUM_CAND-1:0] cand_valid_i,
  output logic                none_o,
  output logic                exactly_one_o,
  output logic                multi_o,
  output logic [IDX_W-1:0]    index_o
);

  logic [NUM_CAND-1:0] low_cleared;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign low_cleared   = cand_valid_i & (cand_valid_i - NUM_CAND'(1));
  assign none_o        = (cand_valid_i == '0);
  assign multi_o       = (low_cleared != '0);
  assign exactly_one_o = !none_o && !multi_o;

  always_comb begin
    index_o = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_valid_i[i]) index_o = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ballot_session_ctrl.sv
// Arms one ballot, accepts exactly one candidate press, then locks out; rejects bad presses.
// Optional REJECT_COUNT_EN adds a saturating reject_count output.
`default_nettype none

module ballot_session_ctrl
  import ballot_ctrl_pkg::*;
#(
  parameter int NUM_CAND    = NUM_CAND_DEF,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int LOCKOUT_CYC = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  ballot_session_ctrl_if.slave bus
);

  localparam int TMR_MAX = max_int(TIMEOUT_CYC, LOCKOUT_CYC);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] LCK_LOAD = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [NUM_CAND-1:0] vote_en_q, vote_en_d;
  logic                ack_q, ack_d;
  logic                reject_q, reject_d;
  logic                timeout_q, timeout_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    total_q, total_d;

  logic                enc_none, enc_one, enc_multi;
  logic [IDX_W-1:0]    enc_index;

  cand_onehot_enc #(
    .NUM_CAND (NUM_CAND),
    .IDX_W    (IDX_W)
  ) u_enc (
    .cand_valid_i  (bus.cand_valid),
    .none_o        (enc_none),
    .exactly_one_o (enc_one),
    .multi_o       (enc_multi),
    .index_o       (enc_index)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    vote_en_d = '0;
    ack_d     = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    total_d   = total_q;
    unique case (state_q)
      CLOSED: begin
        if (bus.session_open) state_d = IDLE;
      end
      IDLE: begin
        if (!bus.session_open) begin
          state_d = CLOSED;
        end else if (bus.arm) begin
          state_d = ARMED;
          tmr_d   = TMO_LOAD;
        end else if (!enc_none) begin
          reject_d = 1'b1;
        end
      end
      ARMED: begin
        if (!bus.session_open) begin
          state_d = CLOSED;
        end else if (enc_one) begin
          // The registered strobe doubles as the latched candidate for the COMMIT cycle.
          state_d   = COMMIT;
          vote_en_d = NUM_CAND'(1) << enc_index;
          ack_d     = 1'b1;
          if (total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
        end else if (enc_multi) begin
          reject_d = 1'b1;
          if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
        end else if (tmr_q == '0) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      COMMIT: begin
        state_d = LOCKOUT;
        tmr_d   = LCK_LOAD;
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = bus.session_open ? IDLE : CLOSED;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = CLOSED;
    endcase
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLOSED;
      tmr_q     <= '0;
      vote_en_q <= '0;
      ack_q     <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      armed_q   <= 1'b0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      vote_en_q <= vote_en_d;
      ack_q     <= ack_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      armed_q   <= armed_d;
      total_q   <= total_d;
    end
  end

`ifdef REJECT_COUNT_EN
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (reject_d && (rcnt_q != CNT_MAX)) rcnt_d = rcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end

  assign bus.reject_count = rcnt_q;
`endif

  assign bus.vote_en      = vote_en_q;
  assign bus.vote_ack     = ack_q;
  assign bus.reject       = reject_q;
  assign bus.timeout      = timeout_q;
  assign bus.ballot_armed = armed_q;
  assign bus.state        = state_q;
  assign bus.total_votes  = total_q;

endmodule

`default_nettype wire

// File: tb/tb_ballot_session_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
`default_nettype none

module tb_ballot_session_ctrl;

  localparam int NC   = 4;
  localparam int CW   = 2;
  localparam int TO   = 20;
  localparam int LK   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ballot_session_ctrl_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

  ballot_session_ctrl #(
    .NUM_CAND    (NC),
    .CNT_W       (CW),
    .TIMEOUT_CYC (TO),
    .LOCKOUT_CYC (LK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model phase uses the published state numbers: 0 closed, 1 idle, 2 armed, 3 commit, 4 lockout.
  int          m_phase, m_age, m_lock, m_total, m_rej;
  logic [NC-1:0] e_vote;
  logic        e_ack, e_rej, e_tmo;

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_lock = 0; m_total = 0; m_rej = 0;
    e_vote = '0; e_ack = 1'b0; e_rej = 1'b0; e_tmo = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic [NC-1:0] cv);
    int n;
    n = $countones(cv);
    e_vote = '0; e_ack = 1'b0; e_rej = 1'b0; e_tmo = 1'b0;
    case (m_phase)
      0: if (s) m_phase = 1;
      1: begin
        if (!s) m_phase = 0;
        else if (a) begin m_phase = 2; m_age = 0; end
        else if (n > 0) e_rej = 1'b1;
      end
      2: begin
        if (!s) m_phase = 0;
        else if (n == 1) begin
          m_phase = 3; e_vote = cv; e_ack = 1'b1;
          if (m_total < CMAX) m_total++;
        end else begin
          if (n > 1) e_rej = 1'b1;
          if (n == 0 && m_age == TO - 1) begin m_phase = 1; e_tmo = 1'b1; end
          else if (m_age < TO - 1) m_age++;
        end
      end
      3: begin m_phase = 4; m_lock = 0; end
      4: begin
        m_lock++;
        if (m_lock == LK) m_phase = s ? 1 : 0;
      end
      default: m_phase = 0;
    endcase
    if (e_rej && m_rej < CMAX) m_rej++;
  endtask

  task automatic cycle(input logic s, input logic a, input logic [NC-1:0] cv);
    bus.session_open = s;
    bus.arm          = a;
    bus.cand_valid   = cv;
    model_step(s, a, cv);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.session_open = 1'b0;
    bus.arm          = 1'b0;
    bus.cand_valid   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.state !== 3'd0)       begin fails++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.vote_en !== 4'b0)     begin fails++; $display("FAIL reset_vote_en got=%b exp=0000", bus.vote_en); end
    checks++; if (bus.vote_ack !== 1'b0)    begin fails++; $display("FAIL reset_ack got=%b exp=0", bus.vote_ack); end
    checks++; if (bus.reject !== 1'b0)      begin fails++; $display("FAIL reset_reject got=%b exp=0", bus.reject); end
    checks++; if (bus.timeout !== 1'b0)     begin fails++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
    checks++; if (bus.ballot_armed !== 1'b0) begin fails++; $display("FAIL reset_armed got=%b exp=0", bus.ballot_armed); end
    checks++; if (bus.total_votes !== 2'd0) begin fails++; $display("FAIL reset_total got=%0d exp=0", bus.total_votes); end
`ifdef REJECT_COUNT_EN
    checks++; if (bus.reject_count !== 2'd0) begin fails++; $display("FAIL reset_rcnt got=%0d exp=0", bus.reject_count); end
`endif
  endtask

  task automatic test_commit();
    do_reset();
    cycle(1'b1, 1'b0, 4'b0000);
    checks++; if (bus.state !== 3'd1) begin fails++; $display("FAIL commit_idle got=%0d exp=1", bus.state); end
    cycle(1'b1, 1'b1, 4'b0000);
    checks++; if (bus.ballot_armed !== 1'b1) begin fails++; $display("FAIL commit_armed got=%b exp=1", bus.ballot_armed); end
    checks++; if (bus.vote_en !== 4'b0000) begin fails++; $display("FAIL commit_pre_vote got=%b exp=0000", bus.vote_en); end
    cycle(1'b1, 1'b0, 4'b0100);
    checks++; if (bus.vote_en !== 4'b0100) begin fails++; $display("FAIL commit_vote_en got=%b exp=0100", bus.vote_en); end
    checks++; if (bus.vote_ack !== 1'b1) begin fails++; $display("FAIL commit_ack got=%b exp=1", bus.vote_ack); end
    checks++; if (bus.total_votes !== 2'd1) begin fails++; $display("FAIL commit_total got=%0d exp=1", bus.total_votes); end
    cycle(1'b1, 1'b0, 4'b0000);
    checks++; if (bus.vote_en !== 4'b0000 || bus.vote_ack !== 1'b0) begin
      fails++; $display("FAIL commit_pulse_len vote_en=%b ack=%b exp 0000/0", bus.vote_en, bus.vote_ack); end
    for (int i = 0; i < LK - 1; i++) begin
      cycle(1'b1, 1'b0, 4'b0000);
      checks++; if (bus.state !== 3'd4) begin fails++; $display("FAIL commit_lockout i=%0d got=%0d exp=4", i, bus.state); end
    end
    cycle(1'b1, 1'b0, 4'b0000);
    checks++; if (bus.state !== 3'd1) begin fails++; $display("FAIL commit_exit got=%0d exp=1", bus.state); end
  endtask

  task automatic test_multi_press();
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b1, 1'b0, 4'b0011);
    checks++; if (bus.reject !== 1'b1) begin fails++; $display("FAIL multi_reject got=%b exp=1", bus.reject); end
    checks++; if (bus.vote_en !== 4'b0000) begin fails++; $display("FAIL multi_vote_en got=%b exp=0000", bus.vote_en); end
    checks++; if (bus.ballot_armed !== 1'b1) begin fails++; $display("FAIL multi_armed got=%b exp=1", bus.ballot_armed); end
    cycle(1'b1, 1'b0, 4'b0001);
    checks++; if (bus.vote_en !== 4'b0001) begin fails++; $display("FAIL multi_then_one got=%b exp=0001", bus.vote_en); end
    checks++; if (bus.total_votes !== 2'(m_total)) begin fails++; $display("FAIL multi_total got=%0d exp=%0d", bus.total_votes, m_total); end
    repeat (LK + 1) cycle(1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_timeout();
    cycle(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < TO - 1; i++) begin
      cycle(1'b1, (i == 5), 4'b0000);
      checks++; if (bus.ballot_armed !== 1'b1 || bus.timeout !== 1'b0) begin
        fails++; $display("FAIL tmo_early i=%0d armed=%b timeout=%b exp 1/0", i, bus.ballot_armed, bus.timeout); end
    end
    cycle(1'b1, 1'b0, 4'b0000);
    checks++; if (bus.timeout !== 1'b1) begin fails++; $display("FAIL tmo_pulse got=%b exp=1", bus.timeout); end
    checks++; if (bus.state !== 3'd1) begin fails++; $display("FAIL tmo_state got=%0d exp=1", bus.state); end
    cycle(1'b1, 1'b0, 4'b0000);
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL tmo_one_cycle got=%b exp=0", bus.timeout); end
    cycle(1'b1, 1'b0, 4'b0010);
    checks++; if (bus.reject !== 1'b1 || bus.vote_en !== 4'b0000) begin
      fails++; $display("FAIL tmo_late_press reject=%b vote_en=%b exp 1/0000", bus.reject, bus.vote_en); end
  endtask

  task automatic test_lockout_press();
    do_reset();
    cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b1, 1'b0, 4'b1000);
    checks++; if (bus.reject !== 1'b1) begin fails++; $display("FAIL idle_press_reject got=%b exp=1", bus.reject); end
`ifdef REJECT_COUNT_EN
    checks++; if (bus.reject_count !== 2'd1) begin fails++; $display("FAIL idle_rcnt got=%0d exp=1", bus.reject_count); end
`endif
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < LK + 1; i++) begin
      cycle(1'b1, 1'b1, 4'($urandom_range(1, 15)));
      checks++; if (bus.reject !== 1'b0 || bus.vote_en !== 4'b0000) begin
        fails++; $display("FAIL lockout_press i=%0d reject=%b vote_en=%b exp 0/0000", i, bus.reject, bus.vote_en); end
    end
    checks++; if (bus.state !== 3'd1) begin fails++; $display("FAIL lockout_exit got=%0d exp=1", bus.state); end
  endtask

  task automatic test_close_armed();
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0100);
    checks++; if (bus.state !== 3'd0 || bus.vote_en !== 4'b0000 || bus.ballot_armed !== 1'b0) begin
      fails++; $display("FAIL close_armed state=%0d vote_en=%b armed=%b exp 0/0000/0", bus.state, bus.vote_en, bus.ballot_armed); end
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL close_no_timeout got=%b exp=0", bus.timeout); end
    repeat (2) begin
      cycle(1'b0, 1'b1, 4'b0000);
      checks++; if (bus.state !== 3'd0) begin fails++; $display("FAIL close_arm_ignored got=%0d exp=0", bus.state); end
    end
    cycle(1'b1, 1'b0, 4'b0000);
    checks++; if (bus.state !== 3'd1) begin fails++; $display("FAIL close_reopen got=%0d exp=1", bus.state); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b1, 1'b0, 4'b0010);
    repeat (LK + 1) cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.state !== 3'd0 || bus.ballot_armed !== 1'b0) begin
      fails++; $display("FAIL arst_state state=%0d armed=%b exp 0/0", bus.state, bus.ballot_armed); end
    checks++; if (bus.total_votes !== 2'd0 || bus.vote_en !== 4'b0000 || bus.reject !== 1'b0 || bus.timeout !== 1'b0) begin
      fails++; $display("FAIL arst_outputs total=%0d vote_en=%b reject=%b timeout=%b exp all 0",
                        bus.total_votes, bus.vote_en, bus.reject, bus.timeout); end
    bus.session_open = 1'b0;
    bus.arm          = 1'b0;
    bus.cand_valid   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    logic [NC-1:0] cv;
    do_reset();
    cycle(1'b1, 1'b0, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      cv = 4'(1 << $urandom_range(0, 3));
      cycle(1'b1, 1'b1, 4'b0000);
      cycle(1'b1, 1'b0, cv);
      checks++; if (bus.vote_en !== cv || bus.vote_ack !== 1'b1) begin
        fails++; $display("FAIL sat_vote k=%0d vote_en=%b ack=%b exp %b/1", k, bus.vote_en, bus.vote_ack, cv); end
      repeat (LK + 1) cycle(1'b1, 1'b0, 4'b0000);
    end
    checks++; if (bus.total_votes !== 2'd3) begin fails++; $display("FAIL sat_total got=%0d exp=3", bus.total_votes); end
  endtask

  task automatic test_random();
    logic          s, a;
    logic [NC-1:0] cv;
    int            r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 99) < 96);
      a = ($urandom_range(0, 9) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 6)      cv = 4'b0000;
      else if (r < 8) cv = 4'(1 << $urandom_range(0, 3));
      else            cv = 4'($urandom_range(0, 15));
      cycle(s, a, cv);
      checks++; if (bus.vote_en !== e_vote) begin fails++; $display("FAIL rnd_vote_en cyc=%0d got=%b exp=%b", i, bus.vote_en, e_vote); end
      checks++; if (bus.vote_ack !== e_ack) begin fails++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, bus.vote_ack, e_ack); end
      checks++; if (bus.reject !== e_rej) begin fails++; $display("FAIL rnd_reject cyc=%0d got=%b exp=%b", i, bus.reject, e_rej); end
      checks++; if (bus.timeout !== e_tmo) begin fails++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", i, bus.timeout, e_tmo); end
      checks++; if (bus.state !== 3'(m_phase)) begin fails++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, bus.state, m_phase); end
      checks++; if (bus.ballot_armed !== (m_phase == 2)) begin
        fails++; $display("FAIL rnd_armed cyc=%0d got=%b exp=%b", i, bus.ballot_armed, (m_phase == 2)); end
      checks++; if (bus.total_votes !== 2'(m_total)) begin
        fails++; $display("FAIL rnd_total cyc=%0d got=%0d exp=%0d", i, bus.total_votes, m_total); end
`ifdef REJECT_COUNT_EN
      checks++; if (bus.reject_count !== 2'(m_rej)) begin
        fails++; $display("FAIL rnd_rcnt cyc=%0d got=%0d exp=%0d", i, bus.reject_count, m_rej); end
`endif
    end
  endtask

  initial begin
    bus.session_open = 1'b0;
    bus.arm          = 1'b0;
    bus.cand_valid   = '0;
    model_reset();
    test_reset();
    test_commit();
    test_multi_press();
    test_timeout();
    test_lockout_press();
    test_close_armed();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
